lieat_clint: RTL and testbench

Core-local interrupt source driving the `time_interrupt` and `msip_interrupt` inputs of the execute-stage CSR unit. It holds the memory-mapped `msip`, `mtimecmp` and `mtime` registers and a free-running 64-bit `mtime` counter with a prescaler. The block serves one-outstanding-request register accesses from the LSU over a valid/ready request/response bus.

---
 rtl/lieat_clint.sv | 148 ++++++++++++++
 tb/tb_lieat_clint.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lieat_clint.sv
`default_nettype none
// ============================================================================
//  Module   : lieat_clint
//  Brief    : Core-local interruptor with msip/mtimecmp/mtime registers, a
//             prescaled 64-bit mtime counter and a valid/ready register bus.
//  Revision : 1.0
// ============================================================================
module lieat_clint #(
    parameter int XLEN     = 32,
    parameter int TICK_DIV = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clint_req_valid,
    output logic            clint_req_ready,
    input  logic            clint_req_write,
    input  logic [15:0]     clint_req_addr,
    input  logic [XLEN-1:0] clint_req_wdata,
    output logic            clint_rsp_valid,
    input  logic            clint_rsp_ready,
    output logic [XLEN-1:0] clint_rsp_rdata,
    output logic            clint_rsp_err,
    output logic            time_interrupt,
    output logic            msip_interrupt
);

    localparam logic [15:0] c_TICK_LAST = 16'(TICK_DIV - 1);

    logic [15:0]     r_tick_cnt;
    logic [63:0]     r_mtime;
    logic [63:0]     r_mtimecmp;
    logic            r_msip;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_rsp_err;
    logic            r_time_irq;
    logic            r_msip_irq;

    logic            w_accept;
    logic            w_wr;
    logic            w_tick;
    logic            w_unmapped;
    logic            w_sel_msip;
    logic            w_sel_cmp_lo;
    logic            w_sel_cmp_hi;
    logic            w_sel_time_lo;
    logic            w_sel_time_hi;
    logic [XLEN-1:0] w_rd_data;
    logic [63:0]     w_mtime_next;

    assign clint_req_ready = !r_rsp_valid || clint_rsp_ready;
    assign w_accept        = clint_req_valid && clint_req_ready;
    assign w_wr            = w_accept && clint_req_write;
    assign w_tick          = (r_tick_cnt == c_TICK_LAST);

    // Address decode; the two byte-offset bits are don't-care.
    always_comb begin
        w_sel_msip    = 1'b0;
        w_sel_cmp_lo  = 1'b0;
        w_sel_cmp_hi  = 1'b0;
        w_sel_time_lo = 1'b0;
        w_sel_time_hi = 1'b0;
        w_unmapped    = 1'b0;
        w_rd_data     = '0;
        casez (clint_req_addr)
            16'b0000_0000_0000_00??: begin
                w_sel_msip = 1'b1;
                w_rd_data  = {{(XLEN-1){1'b0}}, r_msip};
            end
            16'b0100_0000_0000_00??: begin
                w_sel_cmp_lo = 1'b1;
                w_rd_data    = r_mtimecmp[31:0];
            end
            16'b0100_0000_0000_01??: begin
                w_sel_cmp_hi = 1'b1;
                w_rd_data    = r_mtimecmp[63:32];
            end
            16'b1011_1111_1111_10??: begin
                w_sel_time_lo = 1'b1;
                w_rd_data     = r_mtime[31:0];
            end
            16'b1011_1111_1111_11??: begin
                w_sel_time_hi = 1'b1;
                w_rd_data     = r_mtime[63:32];
            end
            default: w_unmapped = 1'b1;
        endcase
    end

    // A software write to either mtime half wins over the prescaled increment.
    always_comb begin
        w_mtime_next = r_mtime;
        if (w_wr && w_sel_time_lo) begin
            w_mtime_next = {r_mtime[63:32], clint_req_wdata};
        end else if (w_wr && w_sel_time_hi) begin
            w_mtime_next = {clint_req_wdata, r_mtime[31:0]};
        end else if (w_tick) begin
            w_mtime_next = r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tick_cnt  <= 16'd0;
            r_mtime     <= 64'd0;
            r_mtimecmp  <= {64{1'b1}};
            r_msip      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_time_irq  <= 1'b0;
            r_msip_irq  <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? 16'd0 : r_tick_cnt + 16'd1;
            r_mtime    <= w_mtime_next;

            if (w_wr && w_sel_cmp_lo) begin
                r_mtimecmp[31:0] <= clint_req_wdata;
            end
            if (w_wr && w_sel_cmp_hi) begin
                r_mtimecmp[63:32] <= clint_req_wdata;
            end
            if (w_wr && w_sel_msip) begin
                r_msip <= clint_req_wdata[0];
            end

            // Interrupts follow the register state of the previous cycle.
            r_time_irq <= (r_mtime >= r_mtimecmp);
            r_msip_irq <= r_msip;

            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= clint_req_write ? '0 : w_rd_data;
                r_rsp_err   <= w_unmapped;
            end else if (clint_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign clint_rsp_valid = r_rsp_valid;
    assign clint_rsp_rdata = r_rsp_rdata;
    assign clint_rsp_err   = r_rsp_err;
    assign time_interrupt  = r_time_irq;
    assign msip_interrupt  = r_msip_irq;

endmodule
`default_nettype wire

// File: tb/tb_lieat_clint.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lieat_clint
//  Brief    : Randomised self-checking bench for lieat_clint against a
//             register-map reference model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_lieat_clint;

    localparam int TDIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        tirq;
    logic        mirq;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [63:0]     m_mtime;
    logic [63:0]     m_cmp;
    logic            m_msip;
    logic            m_tirq;
    logic            m_mirq;
    logic            m_rsp_valid;
    logic [31:0]     m_rdata;
    logic            m_err;
    logic            m_acc;
    longint unsigned m_cycles;

    lieat_clint #(.XLEN(32), .TICK_DIV(TDIV)) dut (
        .clock           (clk),
        .reset           (rst_n),
        .clint_req_valid (req_valid),
        .clint_req_ready (req_ready),
        .clint_req_write (req_write),
        .clint_req_addr  (req_addr),
        .clint_req_wdata (req_wdata),
        .clint_rsp_valid (rsp_valid),
        .clint_rsp_ready (rsp_ready),
        .clint_rsp_rdata (rsp_rdata),
        .clint_rsp_err   (rsp_err),
        .time_interrupt  (tirq),
        .msip_interrupt  (mirq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance one clock edge and apply the register-map rules to the model.
    task automatic tick();
        logic        rdy;
        logic        unm;
        logic [31:0] rv;
        logic [63:0] t_pre;
        logic [63:0] c_pre;
        logic        ms_pre;
        rdy = !m_rsp_valid || rsp_ready;
        @(posedge clk);
        if (!rst_n) begin
            m_mtime = 64'd0; m_cmp = {64{1'b1}}; m_msip = 1'b0;
            m_tirq = 1'b0; m_mirq = 1'b0; m_rsp_valid = 1'b0;
            m_rdata = 32'd0; m_err = 1'b0; m_acc = 1'b0; m_cycles = 0;
        end else begin
            t_pre  = m_mtime;
            c_pre  = m_cmp;
            ms_pre = m_msip;
            m_acc  = req_valid && rdy;
            unm    = 1'b0;
            rv     = 32'd0;
            case (req_addr & 16'hFFFC)
                16'h0000: rv = {31'd0, m_msip};
                16'h4000: rv = m_cmp[31:0];
                16'h4004: rv = m_cmp[63:32];
                16'hBFF8: rv = m_mtime[31:0];
                16'hBFFC: rv = m_mtime[63:32];
                default:  unm = 1'b1;
            endcase
            // mtime advances on every TDIV-th cycle since reset
            if ((m_cycles % TDIV) == TDIV - 1) m_mtime = m_mtime + 64'd1;
            if (m_acc && req_write && !unm) begin
                case (req_addr & 16'hFFFC)
                    16'h0000: m_msip = req_wdata[0];
                    16'h4000: m_cmp[31:0] = req_wdata;
                    16'h4004: m_cmp[63:32] = req_wdata;
                    16'hBFF8: m_mtime = {t_pre[63:32], req_wdata};
                    16'hBFFC: m_mtime = {req_wdata, t_pre[31:0]};
                    default: ;
                endcase
            end
            m_cycles = m_cycles + 1;
            m_tirq = (t_pre >= c_pre);
            m_mirq = ms_pre;
            if (m_acc) begin
                m_rsp_valid = 1'b1;
                m_rdata = req_write ? 32'd0 : rv;
                m_err = unm;
            end else if (rsp_ready) begin
                m_rsp_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 16'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Present one request until accepted (bounded); return observed and model response.
    task automatic do_req(input logic w, input logic [15:0] a, input logic [31:0] d,
                          output logic gv, output logic [31:0] gd, output logic ge,
                          output logic [31:0] ed, output logic ee, output logic ok);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = m_acc;
        end
        req_valid = 1'b0;
        gv = rsp_valid; gd = rsp_rdata; ge = rsp_err;
        ed = m_rdata;   ee = m_err;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", rsp_err); end
        total++; if (tirq !== 1'b0) begin bad++; $display("FAIL reset_tirq: got %b want 0", tirq); end
        total++; if (mirq !== 1'b0) begin bad++; $display("FAIL reset_mirq: got %b want 0", mirq); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_idle_read();
        logic gv, ge, ee, ok;
        logic [31:0] gd, ed;
        for (int i = 0; i < 40; i++) begin
            tick();
            total++; if (tirq !== 1'b0) begin bad++; $display("FAIL idle_tirq: cycle %0d got %b want 0", i, tirq); end
        end
        do_req(1'b0, 16'hBFF8, 32'd0, gv, gd, ge, ed, ee, ok);
        total++;
        if (!ok || gv !== 1'b1 || gd !== ed || ge !== ee) begin
            bad++; $display("FAIL idle_read: ok=%b valid=%b got %h/%b want %h/%b", ok, gv, gd, ge, ed, ee);
        end
        total++; if (gd < 32'd9 || gd > 32'd11) begin bad++; $display("FAIL idle_mtime_range: got %0d want 10+-1", gd); end
        tick();
    endtask

    task automatic test_mtimecmp();
        logic gv, ge, ee, ok;
        logic [31:0] gd, ed, target;
        int rise_m, rise_d;
        do_req(1'b1, 16'h4004, 32'd0, gv, gd, ge, ed, ee, ok);
        total++; if (!ok || gv !== 1'b1 || ge !== 1'b0 || gd !== 32'd0) begin bad++; $display("FAIL cmp_hi_write: ok=%b got %h/%b want 0/0", ok, gd, ge); end
        target = m_mtime[31:0] + 32'd6;
        do_req(1'b1, 16'h4000, target, gv, gd, ge, ed, ee, ok);
        total++; if (!ok || ge !== 1'b0) begin bad++; $display("FAIL cmp_lo_write: ok=%b err got %b want 0", ok, ge); end
        rise_m = -1; rise_d = -1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (rise_m < 0 && m_mtime == {32'd0, target}) rise_m = i;
            if (rise_d < 0 && tirq === 1'b1) rise_d = i;
            total++; if (tirq !== m_tirq) begin bad++; $display("FAIL cmp_tirq: cycle %0d got %b want %b", i, tirq, m_tirq); end
        end
        total++; if (rise_m < 0 || rise_d != rise_m + 1) begin bad++; $display("FAIL cmp_rise_latency: irq at %0d want %0d", rise_d, rise_m + 1); end
        do_req(1'b1, 16'h4000, 32'hFFFF_FFFF, gv, gd, ge, ed, ee, ok);
        total++; if (!ok || tirq !== 1'b1) begin bad++; $display("FAIL cmp_clear_edge: ok=%b tirq got %b want 1", ok, tirq); end
        tick();
        total++; if (tirq !== 1'b0) begin bad++; $display("FAIL cmp_clear_next: tirq got %b want 0", tirq); end
    endtask

    task automatic test_msip();
        logic gv, ge, ee, ok;
        logic [31:0] gd, ed;
        do_req(1'b1, 16'h0000, 32'h3, gv, gd, ge, ed, ee, ok);
        total++; if (!ok || mirq !== 1'b0) begin bad++; $display("FAIL msip_set_edge: ok=%b mirq got %b want 0", ok, mirq); end
        tick();
        total++; if (mirq !== 1'b1) begin bad++; $display("FAIL msip_set_next: mirq got %b want 1", mirq); end
        do_req(1'b0, 16'h0000, 32'd0, gv, gd, ge, ed, ee, ok);
        total++; if (!ok || gv !== 1'b1 || gd !== 32'h1 || ge !== 1'b0) begin bad++; $display("FAIL msip_readback: got %h/%b want 00000001/0", gd, ge); end
        do_req(1'b1, 16'h0000, 32'd0, gv, gd, ge, ed, ee, ok);
        total++; if (!ok || mirq !== 1'b1) begin bad++; $display("FAIL msip_clr_edge: ok=%b mirq got %b want 1", ok, mirq); end
        tick();
        total++; if (mirq !== 1'b0) begin bad++; $display("FAIL msip_clr_next: mirq got %b want 0", mirq); end
    endtask

    task automatic test_carry();
        logic gv, ge, ee, ok;
        logic [31:0] gd, ed, wval;
        do_req(1'b1, 16'hBFFC, 32'd0, gv, gd, ge, ed, ee, ok);
        do_req(1'b1, 16'hBFF8, 32'hFFFF_FFFF, gv, gd, ge, ed, ee, ok);
        for (int i = 0; i < 2 * TDIV; i++) tick();
        do_req(1'b0, 16'hBFFC, 32'd0, gv, gd, ge, ed, ee, ok);
        total++; if (!ok || gd !== 32'd1 || gd !== ed) begin bad++; $display("FAIL carry_hi: got %h want 00000001 (model %h)", gd, ed); end
        // line the write up with an increment edge
        for (int i = 0; i < TDIV && (m_cycles % TDIV) != TDIV - 1; i++) tick();
        wval = $urandom;
        do_req(1'b1, 16'hBFF8, wval, gv, gd, ge, ed, ee, ok);
        do_req(1'b0, 16'hBFF8, 32'd0, gv, gd, ge, ed, ee, ok);
        total++; if (!ok || gd !== wval || gd !== ed) begin bad++; $display("FAIL carry_wr_prio: got %h want %h", gd, wval); end
        tick();
    endtask

    task automatic test_unmapped();
        logic gv, ge, ee, ok;
        logic [31:0] gd, ed;
        logic [63:0] cmp_save;
        logic [15:0] a;
        do_req(1'b0, 16'h1234, 32'd0, gv, gd, ge, ed, ee, ok);
        total++; if (!ok || gv !== 1'b1 || gd !== 32'd0 || ge !== 1'b1) begin bad++; $display("FAIL unm_read: got %h/%b want 0/1", gd, ge); end
        cmp_save = m_cmp;
        do_req(1'b1, 16'h1234, $urandom, gv, gd, ge, ed, ee, ok);
        total++; if (!ok || gd !== 32'd0 || ge !== 1'b1) begin bad++; $display("FAIL unm_write: got %h/%b want 0/1", gd, ge); end
        do_req(1'b0, 16'h4000, 32'd0, gv, gd, ge, ed, ee, ok);
        total++; if (!ok || gd !== cmp_save[31:0] || ge !== 1'b0) begin bad++; $display("FAIL unm_no_side_effect: got %h want %h", gd, cmp_save[31:0]); end
        for (int i = 0; i < 6; i++) begin
            a = 16'h8000 | 16'($urandom_range(0, 16'h0FFF));
            do_req(1'($urandom_range(0, 1)), a, $urandom, gv, gd, ge, ed, ee, ok);
            total++; if (!ok || gd !== 32'd0 || ge !== 1'b1) begin bad++; $display("FAIL unm_rand: addr %h got %h/%b want 0/1", a, gd, ge); end
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic gv, ge, ee, ok;
        logic [31:0] gd, ed, held;
        rsp_ready = 1'b0;
        do_req(1'b0, 16'hBFF8, 32'd0, gv, gd, ge, ed, ee, ok);
        held = gd;
        total++; if (!ok || gd !== ed) begin bad++; $display("FAIL bp_first: got %h want %h", gd, ed); end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4004;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready: cycle %0d got %b want 0", i, req_ready); end
            tick();
            total++; if (rsp_valid !== 1'b1 || rsp_rdata !== held || m_acc) begin bad++; $display("FAIL bp_hold: valid %b rdata %h want 1 %h", rsp_valid, rsp_rdata, held); end
        end
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        total++; if (!m_acc || rsp_valid !== 1'b1 || rsp_rdata !== m_rdata) begin bad++; $display("FAIL bp_release: got %h want %h", rsp_rdata, m_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        req_valid = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!req_valid || m_acc) begin
                case ($urandom_range(0, 6))
                    0: a = 16'h0000;
                    1: a = 16'h4000;
                    2: a = 16'h4004;
                    3: a = 16'hBFF8;
                    4: a = 16'hBFFC;
                    default: a = 16'h7000 | 16'($urandom_range(0, 16'h0FFF));
                endcase
                req_addr  = a | 16'($urandom_range(0, 3));
                req_write = ($urandom_range(0, 2) == 0);
                req_wdata = $urandom;
                req_valid = ($urandom_range(0, 3) != 0);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            total++; if (req_ready !== (!m_rsp_valid || rsp_ready)) begin bad++; $display("FAIL b2b_ready: cycle %0d got %b want %b", i, req_ready, !m_rsp_valid || rsp_ready); end
            tick();
            total++;
            if (rsp_valid !== m_rsp_valid || (m_rsp_valid && (rsp_rdata !== m_rdata || rsp_err !== m_err))) begin
                bad++; $display("FAIL b2b_rsp: cycle %0d got %b %h %b want %b %h %b", i, rsp_valid, rsp_rdata, rsp_err, m_rsp_valid, m_rdata, m_err);
            end
            total++; if (tirq !== m_tirq || mirq !== m_mirq) begin bad++; $display("FAIL b2b_irq: cycle %0d got %b%b want %b%b", i, tirq, mirq, m_tirq, m_mirq); end
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic gv, ge, ee, ok;
        logic [31:0] gd, ed;
        do_req(1'b1, 16'h0000, 32'h1, gv, gd, ge, ed, ee, ok);
        tick();
        rsp_ready = 1'b0;
        do_req(1'b0, 16'h4000, 32'd0, gv, gd, ge, ed, ee, ok);
        rst_n = 1'b0;
        tick();
        total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin bad++; $display("FAIL mid_reset_rsp: got %b %h %b want 0 0 0", rsp_valid, rsp_rdata, rsp_err); end
        total++; if (mirq !== 1'b0 || tirq !== 1'b0) begin bad++; $display("FAIL mid_reset_irq: got %b%b want 00", tirq, mirq); end
        rst_n = 1'b1; rsp_ready = 1'b1;
        tick();
        total++; if (mirq !== 1'b0) begin bad++; $display("FAIL mid_reset_msip: mirq got %b want 0", mirq); end
        do_req(1'b0, 16'h4004, 32'd0, gv, gd, ge, ed, ee, ok);
        total++; if (!ok || gd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mid_reset_cmp: got %h want ffffffff", gd); end
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_read();
        test_mtimecmp();
        test_msip();
        test_carry();
        test_unmapped();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
